// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, 2-flop row synchroniser, press and
// release debounce, one key_valid strobe per accepted press.
`timescale 1ns/1ps
module keypad_scanner #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] row_n,
   output logic [2:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_busy
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

   state_t        r_state;
   logic [3:0]    r_rs1, r_rs2, r_row;
   logic [DW-1:0] r_div;
   logic [1:0]    r_col;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_col_n;
   logic [3:0]    r_key_code;
   logic          r_key_valid, r_key_busy;

   logic          w_sample, w_single, w_idle;
   logic [1:0]    w_col_nxt, w_row_idx;
   logic [2:0]    w_col_n_nxt;
   logic [3:0]    w_code;
   logic [CW-1:0] w_cnt_inc;

   always_comb begin
      w_sample  = (r_div == DIV_LAST);
      w_idle    = (r_rs2 == 4'b1111);
      w_cnt_inc = r_cnt + 1'b1;
      w_col_nxt = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
      unique case (r_rs2)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: w_single = 1'b1;
         default:                            w_single = 1'b0;
      endcase
      case (w_col_nxt)
         2'd0:    w_col_n_nxt = 3'b110;
         2'd1:    w_col_n_nxt = 3'b101;
         default: w_col_n_nxt = 3'b011;
      endcase
      case (r_row)
         4'b1110: w_row_idx = 2'd0;
         4'b1101: w_row_idx = 2'd1;
         4'b1011: w_row_idx = 2'd2;
         default: w_row_idx = 2'd3;
      endcase
      // Bottom row (* 0 #) breaks the row*3+col+1 numbering of the digit rows
      if (w_row_idx == 2'd3) begin
         case (r_col)
            2'd0:    w_code = 4'b1010;
            2'd1:    w_code = 4'b0000;
            default: w_code = 4'b1011;
         endcase
      end else begin
         w_code = ({2'b00, w_row_idx} * 4'd3) + {2'b00, r_col} + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_SCAN;
         r_rs1       <= 4'b1111;
         r_rs2       <= 4'b1111;
         r_row       <= 4'b1111;
         r_div       <= '0;
         r_col       <= 2'd0;
         r_cnt       <= '0;
         r_col_n     <= 3'b110;
         r_key_code  <= 4'b0000;
         r_key_valid <= 1'b0;
         r_key_busy  <= 1'b0;
      end else begin
         r_rs1       <= row_n;
         r_rs2       <= r_rs1;
         r_key_valid <= 1'b0;
         r_div       <= w_sample ? '0 : r_div + 1'b1;
         if (w_sample) begin
            case (r_state)
               S_SCAN: begin
                  if (enable && w_single) begin
                     r_row      <= r_rs2;
                     r_cnt      <= CNT_ONE;
                     r_state    <= S_DEBOUNCE;
                     r_key_busy <= 1'b1;
                  end else begin
                     r_col   <= w_col_nxt;
                     r_col_n <= w_col_n_nxt;
                  end
               end
               S_DEBOUNCE: begin
                  if (r_rs2 == r_row) begin
                     if (w_cnt_inc == CNT_DONE) begin
                        r_key_code  <= w_code;
                        r_key_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_HELD;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt      <= '0;
                     r_state    <= S_SCAN;
                     r_key_busy <= 1'b0;
                     r_col      <= w_col_nxt;
                     r_col_n    <= w_col_n_nxt;
                  end
               end
               S_HELD: begin
                  if (w_idle) begin
                     r_cnt   <= CNT_ONE;
                     r_state <= S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  if (w_idle) begin
                     if (w_cnt_inc == CNT_DONE) begin
                        r_cnt      <= '0;
                        r_state    <= S_SCAN;
                        r_key_busy <= 1'b0;
                        r_col      <= w_col_nxt;
                        r_col_n    <= w_col_n_nxt;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt   <= '0;
                     r_state <= S_HELD;
                  end
               end
            endcase
         end
      end
   end

   assign col_n     = r_col_n;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_busy  = r_key_busy;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled key matrix driven from key masks,
// a strobe monitor fed by an expected-code queue, directed and random presses.
`timescale 1ns/1ps
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [3:0]  row_n;
   logic [2:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid, key_busy;

   logic [11:0] keys;          // bit r*3+c set = key at (row r, col c) pressed
   logic        bounce_open;   // forces the contacts open to emulate bounce
   int          tests = 0, fails = 0, n_strobes = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  last_code;
   logic        prev_valid = 1'b0;

   logic [3:0]  codes [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
   logic [2:0]  col_pat [3] = '{3'b110, 3'b101, 3'b011};

   typedef struct {
      logic [11:0] keys;
      bit          en;
      int          hold;
      int          exp_n;
      logic [3:0]  code;
   } vec_t;
   vec_t vecs [5];

   always #10 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk(clk), .rst(rst), .enable(enable), .row_n(row_n),
      .col_n(col_n), .key_code(key_code), .key_valid(key_valid),
      .key_busy(key_busy)
   );

   always_comb begin
      row_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (keys[r*3+c] && !col_n[c] && !bounce_open) row_n[r] = 1'b0;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Every strobe must match the oldest outstanding expected press
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         n_strobes++;
         check("no_back_to_back", int'(prev_valid), 0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got code 0x%0h expected no strobe", key_code);
         end else begin
            check("strobe_code", int'(key_code), int'(exp_q.pop_front()));
         end
      end
      prev_valid = key_valid;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_col(input logic [2:0] target, input string tag);
      logic [2:0] prev;
      bit found;
      found = 1'b0;
      prev  = col_n;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (col_n == target && prev != target) found = 1'b1;
         prev = col_n;
      end
      check(tag, int'(found), 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_col_n"},     int'(col_n),     int'(3'b110));
      check({tag, "_key_code"},  int'(key_code),  0);
      check({tag, "_key_valid"}, int'(key_valid), 0);
      check({tag, "_key_busy"},  int'(key_busy),  0);
   endtask

   task automatic run_press(input logic [11:0] k, input bit en, input int hold,
                            input int exp_n, input logic [3:0] code, input string tag);
      int s;
      bit busy_seen;
      s = n_strobes;
      busy_seen = 1'b0;
      if (exp_n == 1) begin
         exp_q.push_back(code);
         last_code = code;
      end
      enable = en;
      keys   = k;
      repeat (hold) begin
         @(negedge clk);
         if (key_busy) busy_seen = 1'b1;
      end
      keys   = '0;
      enable = 1'b1;
      if (exp_n == 0) check({tag, "_never_busy"}, int'(busy_seen), 0);
      cycles(60);
      check({tag, "_strobes"},  n_strobes - s,      exp_n);
      check({tag, "_key_code"}, int'(key_code),     int'(last_code));
      check({tag, "_idle"},     int'(key_busy),     0);
   endtask

   initial begin
      int s, idx, hold;
      bit en;

      vecs[0] = '{12'h200, 1'b1, 80, 1, 4'b1010};  // star
      vecs[1] = '{12'h800, 1'b1, 80, 1, 4'b1011};  // hash
      vecs[2] = '{12'h009, 1'b1, 80, 0, 4'b0000};  // 1 and 4 together
      vecs[3] = '{12'h100, 1'b0, 80, 0, 4'b0000};  // 9 with enable low
      vecs[4] = '{12'h400, 1'b1, 80, 1, 4'b0000};  // zero

      keys = '0; bounce_open = 1'b0; enable = 1'b1; rst = 1'b1;
      last_code = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         check($sformatf("idle_scan_%0d", n), int'(col_n), int'(col_pat[(n/4)%3]));
      end

      // '5': exact acceptance latency, long hold, then release timing
      wait_col(3'b101, "t2_col_found");
      s = n_strobes;
      exp_q.push_back(4'b0101);
      last_code = 4'b0101;
      keys = 12'h010;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 3)  check("t2_busy_before_sample", int'(key_busy), 0);
         if (i == 6)  check("t2_busy_debounce", int'(key_busy), 1);
         if (i == 11) check("t2_valid_not_early", int'(key_valid), 0);
         if (i == 12) check("t2_valid_on_time", int'(key_valid), 1);
      end
      cycles(288);
      check("t2_one_strobe", n_strobes - s, 1);
      check("t2_code_held", int'(key_code), 5);
      check("t2_busy_held", int'(key_busy), 1);
      keys = '0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 10) check("t2_busy_release_debounce", int'(key_busy), 1);
         if (i == 14) check("t2_busy_released", int'(key_busy), 0);
      end
      cycles(20);

      for (int v = 0; v < 5; v++)
         run_press(vecs[v].keys, vecs[v].en, vecs[v].hold, vecs[v].exp_n,
                   vecs[v].code, $sformatf("vec%0d", v));

      // '8' with contact bounce, then stable
      s = n_strobes;
      exp_q.push_back(4'b1000);
      last_code = 4'b1000;
      keys = 12'h080;
      for (int k = 0; k < 8; k++) begin
         bounce_open = k[0];
         cycles(5);
      end
      bounce_open = 1'b0;
      check("t4_no_strobe_in_bounce", n_strobes - s, 0);
      cycles(60);
      check("t4_one_strobe", n_strobes - s, 1);
      check("t4_code", int'(key_code), 8);
      keys = '0;
      cycles(60);
      check("t4_idle", int'(key_busy), 0);

      // reset while debouncing '2'
      wait_col(3'b101, "t6_col_found");
      s = n_strobes;
      keys = 12'h002;
      cycles(6);
      check("t6_in_debounce", int'(key_busy), 1);
      rst  = 1'b1;
      keys = '0;
      cycles(2);
      check_reset_values("t6_reset");
      rst = 1'b0;
      last_code = 4'b0000;
      cycles(30);
      check("t6_no_strobe", n_strobes - s, 0);
      run_press(12'h002, 1'b1, 80, 1, 4'b0010, "t6_repress");

      for (int t = 0; t < 12; t++) begin
         idx  = $urandom_range(0, 11);
         en   = ($urandom_range(0, 4) != 0);
         hold = $urandom_range(50, 150);
         run_press(12'(1) << idx, en, hold, en ? 1 : 0, codes[idx],
                   $sformatf("rand%0d", t));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
